pair_line_tx: RTL



---
 rtl/pair_line_pkg.sv | 23 ++
 rtl/pair_line_bit_timer.sv | 31 +++
 rtl/pair_line_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pair_line_pkg.sv
// Shared types and line encoding for the pair-line transmitter.
package pair_line_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [1:0] ENC1_P0 = 2'b00;
    localparam logic [1:0] ENC1_P1 = 2'b11;
    localparam logic [1:0] ENC0_P0 = 2'b10;
    localparam logic [1:0] ENC0_P1 = 2'b01;

    // {a,b} for line bit d at phase p; receiver reads y = d one cycle later.
    function automatic logic [1:0] encode(input logic d, input logic p);
        if (d) return p ? ENC1_P1 : ENC1_P0;
        else   return p ? ENC0_P1 : ENC0_P0;
    endfunction

endpackage

// File: rtl/pair_line_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled, ticks on terminal count.
module pair_line_bit_timer
    import pair_line_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pair_line_tx.sv
// Pair-line serial transmitter: start, DATA_W bits LSB-first, optional even parity, stop.
module pair_line_tx
    import pair_line_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned PARITY_EN  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par, par_n;
    logic [IW-1:0]     idx, idx_n;
    logic              phase, phase_n;
    logic              line_bit_n;
    logic [1:0]        ab_n;
    logic              tick;
    logic              accept;

    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && tick;
    assign in_ready   = (state == IDLE) || frame_done;
    assign accept     = in_valid && in_ready;

    pair_line_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (busy),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        par_n   = par;
        idx_n   = idx;
        phase_n = busy ? ~phase : phase;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    shreg_n = in_data;
                    par_n   = ^in_data;
                    idx_n   = '0;
                    phase_n = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (accept) begin
                        state_n = START;
                        shreg_n = in_data;
                        par_n   = ^in_data;
                        idx_n   = '0;
                        phase_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // a/b are registered, so they are built from the next-cycle state and phase.
        case (state_n)
            START:   line_bit_n = 1'b0;
            DATA:    line_bit_n = shreg_n[0];
            PARITY:  line_bit_n = par_n;
            default: line_bit_n = 1'b1;
        endcase
        ab_n = (state_n == IDLE) ? 2'b00 : encode(line_bit_n, phase_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            par   <= 1'b0;
            idx   <= '0;
            phase <= 1'b0;
            a     <= 1'b0;
            b     <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            par   <= par_n;
            idx   <= idx_n;
            phase <= phase_n;
            {a, b} <= ab_n;
        end
    end

endmodule
